// File: rtl/axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : axil_reg_slave
// Purpose  : AXI4-Lite slave exposing NUM_REGS 32-bit read/write registers.
//            Write address and write data are captured independently (either
//            order or the same cycle) and committed together on the following
//            edge. The read path runs fully independently of the write path.
//            A read that coincides with a commit to the same register returns
//            the pre-write value.
// Ports    : s_axi_aclk / s_axi_aresetn   clock, async active-low reset
//            s_axi_aw* / s_axi_w* / s_axi_b*   write address, data, response
//            s_axi_ar* / s_axi_r*              read address, data
//            reg_out       all register contents, register i at [32i+31:32i]
//            reg_wr_pulse  one-cycle pulse per in-range register commit
//            reg_wr_index  index of the last committed register
// Options  : AXIL_REG_SLAVE_SLVERR_EN - when defined, out-of-range accesses
//            answer SLVERR (2'b10); otherwise every access answers OKAY.
// Revision : 1.0 - initial release
// ============================================================================
module axil_reg_slave #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS       = 16
) (
    input  logic                               s_axi_aclk,
    input  logic                               s_axi_aresetn,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                               s_axi_awvalid,
    output logic                               s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                               s_axi_wvalid,
    output logic                               s_axi_wready,
    output logic [1:0]                         s_axi_bresp,
    output logic                               s_axi_bvalid,
    input  logic                               s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                               s_axi_arvalid,
    output logic                               s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                         s_axi_rresp,
    output logic                               s_axi_rvalid,
    input  logic                               s_axi_rready,
    output logic [NUM_REGS*AXI_DATA_WIDTH-1:0] reg_out,
    output logic                               reg_wr_pulse,
    output logic [7:0]                         reg_wr_index
);

    localparam int c_IDX_W  = $clog2(NUM_REGS);
    localparam int c_STRB_W = AXI_DATA_WIDTH / 8;

`ifdef AXIL_REG_SLAVE_SLVERR_EN
    localparam logic c_SLVERR_EN = 1'b1;
`else
    localparam logic c_SLVERR_EN = 1'b0;
`endif

    // Readies stay low until the first edge after reset release.
    logic                          r_ready_en;

    logic                          r_aw_held;
    logic [AXI_ADDR_WIDTH-1:0]     r_aw_addr;
    logic                          r_w_held;
    logic [AXI_DATA_WIDTH-1:0]     r_wdata;
    logic [c_STRB_W-1:0]           r_wstrb;
    logic                          r_bvalid;
    logic [1:0]                    r_bresp;
    logic                          r_wr_pulse;
    logic [7:0]                    r_wr_index;

    logic                          r_rvalid;
    logic [AXI_DATA_WIDTH-1:0]     r_rdata;
    logic [1:0]                    r_rresp;

    logic [AXI_DATA_WIDTH-1:0]     r_regs [NUM_REGS];

    logic                          w_aw_hs;
    logic                          w_w_hs;
    logic                          w_ar_hs;
    logic                          w_commit;
    logic                          w_aw_in_range;
    logic                          w_ar_in_range;
    logic [c_IDX_W-1:0]            w_aw_idx;
    logic [c_IDX_W-1:0]            w_ar_idx;
    logic [1:0]                    w_aw_resp;
    logic [1:0]                    w_ar_resp;

    assign s_axi_awready = r_ready_en & ~r_aw_held & ~r_bvalid;
    assign s_axi_wready  = r_ready_en & ~r_w_held  & ~r_bvalid;
    assign s_axi_arready = r_ready_en & ~r_rvalid;

    assign w_aw_hs  = s_axi_awvalid & s_axi_awready;
    assign w_w_hs   = s_axi_wvalid  & s_axi_wready;
    assign w_ar_hs  = s_axi_arvalid & s_axi_arready;
    assign w_commit = r_aw_held & r_w_held;

    // Anything above the register window makes the access out of range;
    // the byte offset in addr[1:0] is shifted away and never consulted.
    assign w_aw_in_range = ((r_aw_addr    >> (c_IDX_W + 2)) == '0);
    assign w_ar_in_range = ((s_axi_araddr >> (c_IDX_W + 2)) == '0);
    assign w_aw_idx      = r_aw_addr[c_IDX_W+1:2];
    assign w_ar_idx      = s_axi_araddr[c_IDX_W+1:2];

    assign w_aw_resp = (c_SLVERR_EN && !w_aw_in_range) ? 2'b10 : 2'b00;
    assign w_ar_resp = (c_SLVERR_EN && !w_ar_in_range) ? 2'b10 : 2'b00;

    // ------------------------------------------------------------------
    // Write channel control: capture AW and W, commit, hold response.
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_ready_en <= 1'b0;
            r_aw_held  <= 1'b0;
            r_aw_addr  <= '0;
            r_w_held   <= 1'b0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= 1'b0;
            r_wr_index <= 8'd0;
        end else begin
            r_ready_en <= 1'b1;
            r_wr_pulse <= 1'b0;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_axi_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb;
            end
            // Captures only happen while bvalid is low, so a commit can
            // never overlap a pending response.
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_aw_resp;
                if (w_aw_in_range) begin
                    r_wr_pulse <= 1'b1;
                    r_wr_index <= 8'(w_aw_idx);
                end
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file with byte-lane writes.
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_aw_in_range) begin
            for (int b = 0; b < c_STRB_W; b++) begin
                if (r_wstrb[b]) begin
                    r_regs[w_aw_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel. r_regs is sampled before any same-edge commit lands,
    // which gives the pre-write value on a read/write collision.
    // ------------------------------------------------------------------
    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_in_range ? r_regs[w_ar_idx] : '0;
            r_rresp  <= w_ar_resp;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
            assign reg_out[AXI_DATA_WIDTH*i +: AXI_DATA_WIDTH] = r_regs[i];
        end
    endgenerate

    assign s_axi_bvalid = r_bvalid;
    assign s_axi_bresp  = r_bresp;
    assign s_axi_rvalid = r_rvalid;
    assign s_axi_rdata  = r_rdata;
    assign s_axi_rresp  = r_rresp;
    assign reg_wr_pulse = r_wr_pulse;
    assign reg_wr_index = r_wr_index;

endmodule
`default_nettype wire

// File: tb/tb_axil_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axil_reg_slave
// Purpose  : Self-checking bench for axil_reg_slave (NUM_REGS = 16). Directed
//            scenarios plus randomized reads/writes are compared against a
//            word-array model of the register file.
// Options  : honours AXIL_REG_SLAVE_SLVERR_EN for the expected responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axil_reg_slave;

    localparam int c_NR = 16;
    localparam int c_W  = c_NR * 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [31:0]     awaddr;
    logic            awvalid;
    logic            awready;
    logic [31:0]     wdata;
    logic [3:0]      wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [31:0]     araddr;
    logic            arvalid;
    logic            arready;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;
    logic [c_W-1:0]  reg_out;
    logic            reg_wr_pulse;
    logic [7:0]      reg_wr_index;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mdl [c_NR];

    axil_reg_slave #(
        .AXI_ADDR_WIDTH (32),
        .AXI_DATA_WIDTH (32),
        .NUM_REGS       (c_NR)
    ) u_dut (
        .s_axi_aclk    (clk),
        .s_axi_aresetn (rst_n),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_out       (reg_out),
        .reg_wr_pulse  (reg_wr_pulse),
        .reg_wr_index  (reg_wr_index)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [c_W-1:0] got, input logic [c_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [c_W-1:0] mdl_vec();
        logic [c_W-1:0] v;
        for (int i = 0; i < c_NR; i++) v[32*i +: 32] = mdl[i];
        return v;
    endfunction

    function automatic bit in_range(input logic [31:0] a);
        return (a < 32'(c_NR * 4));
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] a);
`ifdef AXIL_REG_SLAVE_SLVERR_EN
        return in_range(a) ? 2'b00 : 2'b10;
`else
        return (a == a) ? 2'b00 : 2'b00;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < c_NR; i++) mdl[i] = 32'd0;
    endtask

    task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (!in_range(a)) return;
        idx = int'(a / 4);
        for (int b = 0; b < 4; b++)
            if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
    endtask

    // Full write transaction: AW and W presented after independent delays,
    // response held off for b_dly cycles.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done  = 0;
        bit hs_aw, hs_w;
        int c = 0;
        logic [1:0] er;
        bready = 1'b0;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        while (!(aw_done && w_done)) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done  && (c >= w_dly);
            hs_aw   = awvalid && awready;
            hs_w    = wvalid  && wready;
            step();
            if (hs_aw) aw_done = 1;
            if (hs_w)  w_done  = 1;
            c++;
            if (c > 60) begin
                chk("wr_timeout", 0, 1);
                awvalid = 1'b0;
                wvalid  = 1'b0;
                return;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("b_early", bvalid, 0);
        step();
        er = exp_resp(a);
        chk("bvalid", bvalid, 1);
        chk("bresp", bresp, er);
        chk("wr_pulse", reg_wr_pulse, in_range(a));
        if (in_range(a)) chk("wr_index", reg_wr_index, a[5:2]);
        mdl_write(a, d, s);
        chk("reg_out", reg_out, mdl_vec());
        for (int i = 0; i < b_dly; i++) begin
            step();
            chk("b_hold", {bvalid, bresp, awready, wready, reg_wr_pulse}, {1'b1, er, 3'b000});
        end
        bready = 1'b1;
        step();
        chk("b_clear", bvalid, 0);
        bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly);
        bit hs = 0;
        int c = 0;
        logic [31:0] ed;
        araddr = a;
        rready = 1'b0;
        while (!hs) begin
            arvalid = (c >= ar_dly);
            hs      = arvalid && arready;
            step();
            c++;
            if (c > 60) begin
                chk("rd_timeout", 0, 1);
                arvalid = 1'b0;
                return;
            end
        end
        arvalid = 1'b0;
        ed = in_range(a) ? mdl[int'(a / 4)] : 32'd0;
        chk("rvalid", rvalid, 1);
        chk("rdata", rdata, ed);
        chk("rresp", rresp, exp_resp(a));
        for (int i = 0; i < r_dly; i++) begin
            step();
            chk("r_hold", {rvalid, arready, rdata}, {1'b1, 1'b0, ed});
        end
        rready = 1'b1;
        step();
        chk("r_clear", rvalid, 0);
        rready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;

        rst_n   = 1'b0;
        awaddr  = '0; awvalid = 1'b0;
        wdata   = '0; wstrb   = '0; wvalid = 1'b0;
        bready  = 1'b0;
        araddr  = '0; arvalid = 1'b0;
        rready  = 1'b0;
        mdl_clear();

        repeat (3) step();
        chk("rst_ready", {awready, wready, arready}, 3'b000);
        chk("rst_valid", {bvalid, rvalid, reg_wr_pulse}, 3'b000);
        chk("rst_regs", reg_out, mdl_vec());
        chk("rst_misc", {reg_wr_index, rdata, bresp, rresp}, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", {awready, wready, arready}, 3'b000);
        step();
        chk("ready_after_edge", {awready, wready, arready}, 3'b111);

        // Same-cycle AW/W, immediate bready.
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("req021_reg2", reg_out[95:64], 32'hDEADBEEF);

        // W leads AW by three cycles, partial strobe.
        do_write(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        do_write(32'h04, 32'h11223344, 4'h5, 3, 0, 0);
        chk("req022_reg1", reg_out[63:32], 32'hFF22FF44);

        // Read with long rready backpressure.
        do_read(32'h08, 0, 10);

        // Out-of-range write and read.
        do_write(32'h40, 32'h12345678, 4'hF, 1, 0, 2);
        do_read(32'h40, 0, 1);

        // Read and commit collide on reg 3.
        do_write(32'h0C, 32'h1, 4'hF, 0, 0, 0);
        awaddr = 32'h0C; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        araddr = 32'h0C; rready = 1'b0;
        step();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        mdl_write(32'h0C, 32'h2, 4'hF);
        chk("coll_rvalid", {rvalid, bvalid}, 2'b11);
        chk("coll_rdata", rdata, 32'h1);
        chk("coll_reg_out", reg_out, mdl_vec());
        rready = 1'b1;
        step();
        chk("coll_clear", {rvalid, bvalid}, 2'b00);
        rready = 1'b0; bready = 1'b0;
        do_read(32'h0C, 0, 0);

        // Reset with AW held and W pending.
        awaddr = 32'h10; awvalid = 1'b1;
        wdata  = 32'hCAFEF00D; wstrb = 4'hF; wvalid = 1'b0;
        step();
        awvalid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mdl_clear();
        chk("arst_regs", reg_out, mdl_vec());
        chk("arst_out", {bvalid, rvalid, awready, wready, arready, reg_wr_pulse, reg_wr_index}, 0);
        wvalid = 1'b1;
        repeat (2) step();
        wvalid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("arst_no_b", bvalid, 0);
        chk("arst_ready", {awready, wready, arready}, 3'b111);
        chk("arst_regs2", reg_out, mdl_vec());
        do_write(32'h10, 32'hA5A5A5A5, 4'hF, 0, 1, 1);

        // Randomized traffic.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 8)
                a = 32'($urandom_range(0, c_NR - 1) * 4 + $urandom_range(0, 3));
            else
                a = 32'(c_NR * 4) + ($urandom & 32'h0FFF_FFFF);
            if ($urandom_range(0, 1) == 1) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else begin
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
        chk("final_regs", reg_out, mdl_vec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
